histo_read_arbiter: RTL and testbench

Shares the single histogram read port (gray-level read address in, histogram and cumulative-histogram counts out, fixed 3-cycle latency) between up to three clients: LCD histogram overlay, contrast-stretch LUT builder, UART dumper. Each client requests a burst of consecutive gray levels. The arbiter grants whole bursts round-robin and drives the read address one level per cycle. It returns each count tagged with the requester id, the gray level and a last-of-burst flag.

---
 rtl/histo_rd_pkg.sv | 41 ++++
 rtl/histo_rd_tagpipe.sv | 41 ++++
 rtl/histo_read_arbiter.sv | 164 ++++++++++++++++
 tb/tb_histo_read_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/histo_rd_pkg.sv
// histo_rd_pkg: shared constants and types for the histogram read-port
// arbiter and its tag pipe.
//   NREQ   number of clients sharing the read port
//   LAT    read latency of the histogram block (address -> data)
//   DW     histogram count width
//   GRAY_W gray-level (read address) width
package histo_rd_pkg;

    localparam int NREQ   = 3;
    localparam int LAT    = 3;
    localparam int DW     = 20;
    localparam int GRAY_W = 8;
    localparam int LEN_W  = 9;
    localparam int ID_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Travels alongside each read address so the response can be labelled
    // once the data comes back LAT cycles later.
    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [GRAY_W-1:0] gray;
        logic              last;
    } tag_t;

    // A zero-length request still reads one level; anything above the
    // full table size is clamped to one full pass over the table.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return 9'd1;
        else if (len > 9'd256)
            return 9'd256;
        else
            return len;
    endfunction

endpackage

// File: rtl/histo_rd_tagpipe.sv
// histo_rd_tagpipe: DEPTH-stage shift register of read tags, aligned with
// the read latency of a memory port.
//   iClk      clock
//   iRst      synchronous active-high clear of every stage
//   iTag      tag entering the pipe this cycle
//   oTag      tag leaving the pipe (aligned with memory read data)
//   oAnyValid high while any stage holds a valid tag
module histo_rd_tagpipe
    import histo_rd_pkg::*;
#(
    parameter int DEPTH = LAT
) (
    input  logic iClk,
    input  logic iRst,
    input  tag_t iTag,
    output tag_t oTag,
    output logic oAnyValid
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++)
                pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= iTag;
            for (int i = 1; i < DEPTH; i++)
                pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign oTag = pipe_q[DEPTH-1];

    always_comb begin
        oAnyValid = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            oAnyValid = oAnyValid | pipe_q[i].valid;
    end

endmodule

// File: rtl/histo_read_arbiter.sv
// histo_read_arbiter: shares the histogram read port between NREQ clients.
// Whole bursts are granted round-robin; each burst drives one gray level
// per cycle and every returned count is tagged with id, gray and last.
//   iClk, iRst              clock, synchronous active-high reset
//   iReq/iStart/iLen        per-client burst request, first level, length
//   iHold                   blocks new bursts (only sampled when idle)
//   oGrant                  one-cycle one-hot burst-accepted pulse
//   oReadGray               read address to the histogram block
//   iGrayHisto/iGrayCumHisto  counts returned LAT cycles after the address
//   oValid/oId/oGray/oLast  registered response tag
//   oHisto/oCumHisto        registered counts
//   oBusy                   burst issuing or responses still in flight
module histo_read_arbiter
    import histo_rd_pkg::*;
(
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [NREQ-1:0]        iReq,
    input  logic [NREQ*GRAY_W-1:0] iStart,
    input  logic [NREQ*LEN_W-1:0]  iLen,
    input  logic                   iHold,
    output logic [NREQ-1:0]        oGrant,
    output logic [GRAY_W-1:0]      oReadGray,
    input  logic [DW-1:0]          iGrayHisto,
    input  logic [DW-1:0]          iGrayCumHisto,
    output logic                   oValid,
    output logic [ID_W-1:0]        oId,
    output logic [GRAY_W-1:0]      oGray,
    output logic [DW-1:0]          oHisto,
    output logic [DW-1:0]          oCumHisto,
    output logic                   oLast,
    output logic                   oBusy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [GRAY_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [NREQ-1:0]   grant_q, grant_d;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    tag_t              push_tag, pipe_out;
    logic              pipe_busy;

    // Round-robin pick: scan clients starting at ptr, wrapping at NREQ.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!win_vld && iReq[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    // addr_q stops advancing on the last issue so oReadGray holds the last
    // level driven for as long as the arbiter sits idle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        grant_d  = '0;
        push_tag = '0;
        case (state_q)
            IDLE: begin
                if (win_vld && !iHold) begin
                    state_d         = BURST;
                    id_d            = win_id;
                    addr_d          = iStart[win_id*GRAY_W +: GRAY_W];
                    rem_d           = eff_len(iLen[win_id*LEN_W +: LEN_W]);
                    ptr_d           = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 2'd1;
                    grant_d[win_id] = 1'b1;
                end
            end
            BURST: begin
                push_tag.valid = 1'b1;
                push_tag.id    = id_q;
                push_tag.gray  = addr_q;
                push_tag.last  = (rem_q == 9'd1);
                rem_d          = rem_q - 9'd1;
                if (rem_q == 9'd1)
                    state_d = IDLE;
                else
                    addr_d = addr_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            grant_q <= grant_d;
        end
    end

    histo_rd_tagpipe #(.DEPTH(LAT)) u_tagpipe (
        .iClk      (iClk),
        .iRst      (iRst),
        .iTag      (push_tag),
        .oTag      (pipe_out),
        .oAnyValid (pipe_busy)
    );

    // Response register: data outputs only move when a tag arrives.
    logic              valid_q;
    logic [ID_W-1:0]   rid_q;
    logic [GRAY_W-1:0] rgray_q;
    logic              rlast_q;
    logic [DW-1:0]     rhisto_q, rcum_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q  <= 1'b0;
            rid_q    <= '0;
            rgray_q  <= '0;
            rlast_q  <= 1'b0;
            rhisto_q <= '0;
            rcum_q   <= '0;
        end else if (pipe_out.valid) begin
            valid_q  <= 1'b1;
            rid_q    <= pipe_out.id;
            rgray_q  <= pipe_out.gray;
            rlast_q  <= pipe_out.last;
            rhisto_q <= iGrayHisto;
            rcum_q   <= iGrayCumHisto;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign oGrant    = grant_q;
    assign oReadGray = addr_q;
    assign oValid    = valid_q;
    assign oId       = rid_q;
    assign oGray     = rgray_q;
    assign oLast     = rlast_q;
    assign oHisto    = rhisto_q;
    assign oCumHisto = rcum_q;
    // The response register counts as in flight, so busy covers the final
    // response cycle and drops on the cycle after it.
    assign oBusy     = (state_q == BURST) || pipe_busy || valid_q;

endmodule

// File: tb/tb_histo_read_arbiter.sv
`timescale 1ns/1ps
module tb_histo_read_arbiter;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [2:0]  iReq = '0;
    logic [23:0] iStart = '0;
    logic [26:0] iLen = '0;
    logic        iHold = 1'b0;
    logic [2:0]  oGrant;
    logic [7:0]  oReadGray;
    logic [19:0] iGrayHisto, iGrayCumHisto;
    logic        oValid;
    logic [1:0]  oId;
    logic [7:0]  oGray;
    logic [19:0] oHisto, oCumHisto;
    logic        oLast, oBusy;

    histo_read_arbiter dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iStart(iStart), .iLen(iLen),
        .iHold(iHold), .oGrant(oGrant), .oReadGray(oReadGray),
        .iGrayHisto(iGrayHisto), .iGrayCumHisto(iGrayCumHisto),
        .oValid(oValid), .oId(oId), .oGray(oGray), .oHisto(oHisto),
        .oCumHisto(oCumHisto), .oLast(oLast), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Histogram block model: 3-cycle read latency.
    logic [19:0] hmem [256];
    logic [19:0] cmem [256];
    logic [7:0]  d1 = '0, d2 = '0, d3 = '0;
    always @(posedge iClk) begin
        d1 <= oReadGray;
        d2 <= d1;
        d3 <= d2;
    end
    assign iGrayHisto    = hmem[d3];
    assign iGrayCumHisto = cmem[d3];

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  gray;
        logic        last;
        logic [19:0] h;
        logic [19:0] c;
    } resp_t;
    typedef struct {
        int id;
        int start;
        int eff;
    } gnt_t;

    resp_t sb[$];
    gnt_t  gq[$];
    int    mptr = 0;
    int    tests = 0, fails = 0;
    int    first_gcyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every response must match the head of the queue.
    resp_t e;
    always @(negedge iClk) begin
        if (oValid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'(oValid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp", {oId, oGray, oLast, oHisto, oCumHisto},
                      {e.id, e.gray, e.last, e.h, e.c});
            end
        end
    end

    // Raise the masked requests and predict the whole service order:
    // clients present at once are served in ascending order starting at
    // the round-robin pointer.
    task automatic request(input logic [2:0] mask, input int st[3], input int ln[3]);
        int nptr;
        nptr = mptr;
        @(posedge iClk); #1;
        for (int c = 0; c < 3; c++) begin
            if (mask[c]) begin
                iStart[c*8 +: 8] = st[c][7:0];
                iLen[c*9 +: 9]   = ln[c][8:0];
            end
        end
        for (int i = 0; i < 3; i++) begin
            int c, l, ef;
            c = (mptr + i) % 3;
            if (mask[c]) begin
                l  = ln[c] % 512;
                ef = (l == 0) ? 1 : ((l > 256) ? 256 : l);
                gq.push_back('{c, st[c] % 256, ef});
                for (int k = 0; k < ef; k++) begin
                    int g;
                    g = (st[c] + k) % 256;
                    sb.push_back('{2'(c), 8'(g), (k == ef - 1), hmem[g], cmem[g]});
                end
                nptr = (c + 1) % 3;
            end
        end
        mptr = nptr;
        iReq = iReq | mask;
    endtask

    task automatic collect_grants();
        int   pc, pe, n;
        bit   first;
        gnt_t g;
        pc = 0; pe = 0; first = 1'b1;
        while (gq.size() > 0) begin
            g = gq.pop_front();
            n = 0;
            do begin
                @(negedge iClk);
                n++;
            end while (oGrant == 3'b000 && n < 600);
            check("grant_seen", 64'(oGrant != 3'b000), 64'd1);
            if (oGrant == 3'b000) begin
                gq.delete();
                return;
            end
            check("grant_id", 64'(oGrant), 64'(3'b001 << g.id));
            check("grant_addr", 64'(oReadGray), 64'(g.start));
            if (!first) check("grant_gap", 64'(cyc - pc), 64'(pe + 1));
            else        first_gcyc = cyc;
            first = 1'b0;
            pc = cyc;
            pe = g.eff;
            iReq = iReq & ~oGrant;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || oBusy) && n < 2000) begin
            @(negedge iClk);
            n++;
        end
        check("drain", {63'(sb.size()), oBusy}, 64'd0);
    endtask

    task automatic check_reset_outs(input string nm);
        check(nm, {oGrant, oReadGray, oValid, oId, oGray, oHisto, oCumHisto, oLast, oBusy}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] acc;
        int rel, n, lastid;
        acc = '0;
        for (int i = 0; i < 256; i++) begin
            hmem[i] = 20'($urandom);
            acc     = acc + hmem[i];
            cmem[i] = acc;
        end

        // Reset state
        iRst = 1'b1;
        repeat (3) @(posedge iClk);
        #1 iRst = 1'b0;
        @(negedge iClk);
        check_reset_outs("reset_outs");

        // Single burst: client 1, start 10, len 4; first response 4 cycles after grant
        request(3'b010, '{0, 10, 0}, '{0, 4, 0});
        collect_grants();
        repeat (4) @(negedge iClk);
        check("first_resp", {oValid, oId, oGray}, {1'b1, 2'd1, 8'd10});
        drain();

        // Wrap, len=0, len clamp
        request(3'b100, '{0, 0, 250}, '{0, 0, 8});
        collect_grants(); drain();
        request(3'b001, '{77, 0, 0}, '{0, 0, 0});
        collect_grants(); drain();
        request(3'b010, '{0, 5, 0}, '{0, 300, 0});
        collect_grants(); drain();

        // Hold blocks grants; release grants one cycle later
        iHold = 1'b1;
        request(3'b100, '{0, 0, 40}, '{0, 0, 3});
        repeat (10) begin
            @(negedge iClk);
            check("hold_nogrant", 64'(oGrant), 64'd0);
        end
        @(posedge iClk); #1;
        iHold = 1'b0;
        rel = cyc;
        collect_grants();
        check("hold_release", 64'(first_gcyc - rel), 64'd1);
        drain();

        // Hold raised mid-burst: the burst still completes
        request(3'b001, '{100, 0, 0}, '{8, 0, 0});
        collect_grants();
        iHold = 1'b1;
        drain();
        iHold = 1'b0;

        // Reset after the 3rd address of an 8-long burst
        request(3'b010, '{0, 200, 0}, '{0, 8, 0});
        collect_grants();
        repeat (3) @(posedge iClk);
        #1 iRst = 1'b1;
        sb.delete();
        @(posedge iClk);
        #1 iRst = 1'b0;
        mptr = 0;
        @(negedge iClk);
        check_reset_outs("midburst_reset_outs");
        repeat (8) begin
            @(negedge iClk);
            check("post_reset_quiet", 64'(oValid), 64'd0);
        end

        // Round-robin from ptr 0, then busy timing around the final response
        request(3'b111, '{20, 30, 40}, '{2, 2, 2});
        collect_grants();
        request(3'b001, '{60, 0, 0}, '{2, 0, 0});
        collect_grants();
        request(3'b110, '{0, 90, 120}, '{0, 3, 5});
        collect_grants();
        lastid = 2;
        n = 0;
        while (!(oValid && oLast && oId == 2'(lastid)) && n < 1000) begin
            @(negedge iClk);
            n++;
        end
        check("busy_at_last", {oValid, oLast, oBusy}, 64'b111);
        @(negedge iClk);
        check("busy_after_last", 64'(oBusy), 64'd0);
        drain();

        // Randomized request sets
        for (int it = 0; it < 20; it++) begin
            int st[3], ln[3];
            logic [2:0] m;
            m = 3'($urandom_range(1, 7));
            for (int c = 0; c < 3; c++) begin
                st[c] = int'($urandom_range(0, 255));
                ln[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 511))
                                                    : int'($urandom_range(0, 12));
            end
            request(m, st, ln);
            collect_grants();
            drain();
        end

        repeat (5) @(negedge iClk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
